// File: rtl/minmax_pkg.sv
// Shared types and helpers for the windowed min/max tracker.
package minmax_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        TRACK  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Counter width able to hold 0..window inclusive.
    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/minmax_tracker_mag_cmp.sv
// Combinational magnitude comparator: a vs b -> gt/lt/eq.
// Define MINMAX_SIGNED_EN to compare as two's-complement; otherwise unsigned.
module mag_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    // Three-way decision; eq is the same in both number systems.
    always_comb begin
`ifdef MINMAX_SIGNED_EN
        gt = $signed(a) > $signed(b);
        lt = $signed(a) < $signed(b);
`else
        gt = a > b;
        lt = a < b;
`endif
        eq = (a == b);
    end

endmodule

// File: rtl/minmax_tracker.sv
// Windowed running max/min tracker with held result handshake.
// Comparison signedness follows MINMAX_SIGNED_EN (see mag_cmp).
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 10,
    parameter int CNT_W  = cnt_width(WINDOW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_max,
    output logic [WIDTH-1:0] res_min,
    output logic [CNT_W-1:0] res_cnt,
    output logic             new_max,
    output logic             new_min
);

    localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             new_max_q, new_max_d;
    logic             new_min_q, new_min_d;

    logic             gt_max, lt_max, eq_max;
    logic             gt_min, lt_min, eq_min;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             unused_cmp;

    mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
        .a  (in_data),
        .b  (max_q),
        .gt (gt_max),
        .lt (lt_max),
        .eq (eq_max)
    );

    mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
        .a  (in_data),
        .b  (min_q),
        .gt (gt_min),
        .lt (lt_min),
        .eq (eq_min)
    );

    // Only sample>max and sample<min matter; equality needs no action.
    assign unused_cmp = ^{lt_max, eq_max, gt_min, eq_min};

    // in_ready is registered, so acceptance never waits on in_valid.
    assign accept  = in_valid && in_ready_q;
    assign cnt_inc = cnt_q + 1'b1;

    // Next-state, extreme update and pulse generation.
    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        min_d     = min_q;
        cnt_d     = cnt_q;
        new_max_d = 1'b0;
        new_min_d = 1'b0;
        unique case (state_q)
            EMPTY: begin
                // First sample seeds both extremes; flush alone is ignored.
                if (accept) begin
                    max_d   = in_data;
                    min_d   = in_data;
                    cnt_d   = CNT_W'(1);
                    state_d = (WINDOW == 1) ? REPORT : TRACK;
                end
            end
            TRACK: begin
                if (accept) begin
                    if (gt_max) begin
                        max_d     = in_data;
                        new_max_d = 1'b1;
                    end
                    if (lt_min) begin
                        min_d     = in_data;
                        new_min_d = 1'b1;
                    end
                    cnt_d = cnt_inc;
                    if (cnt_inc == WIN_C) state_d = REPORT;
                end
                // Sample (if any) is folded in above before the window closes.
                if (flush) state_d = REPORT;
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = EMPTY;
                    max_d   = '0;
                    min_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d  = (state_d != REPORT);
        res_valid_d = (state_d == REPORT);
    end

    // State and datapath registers; everything clears to 0 on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            max_q       <= '0;
            min_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            new_max_q   <= 1'b0;
            new_min_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            max_q       <= max_d;
            min_q       <= min_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            new_max_q   <= new_max_d;
            new_min_q   <= new_min_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_max   = max_q;
    assign res_min   = min_q;
    assign res_cnt   = cnt_q;
    assign new_max   = new_max_q;
    assign new_min   = new_min_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Randomized + directed bench for minmax_tracker against a window-queue model.
module tb_minmax_tracker;

    localparam int WIDTH  = 4;
    localparam int WINDOW = 4;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_max;
    logic [WIDTH-1:0] res_min;
    logic [CNT_W-1:0] res_cnt;
    logic             new_max;
    logic             new_min;

    int errors = 0;
    int checks = 0;

    // Model: the current window's samples, plus report/ready flags.
    logic [WIDTH-1:0] win[$];
    bit               m_rep = 1'b0;
    bit               m_rdy = 1'b0;
    bit               e_nmax = 1'b0;
    bit               e_nmin = 1'b0;

    minmax_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_max   (res_max),
        .res_min   (res_min),
        .res_cnt   (res_cnt),
        .new_max   (new_max),
        .new_min   (new_min)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sv(input logic [WIDTH-1:0] x);
`ifdef MINMAX_SIGNED_EN
        return int'($signed(x));
`else
        return int'(x);
`endif
    endfunction

    function automatic logic [WIDTH-1:0] wmax();
        logic [WIDTH-1:0] m;
        if (win.size() == 0) return '0;
        m = win[0];
        foreach (win[i]) if (sv(win[i]) > sv(m)) m = win[i];
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] wmin();
        logic [WIDTH-1:0] m;
        if (win.size() == 0) return '0;
        m = win[0];
        foreach (win[i]) if (sv(win[i]) < sv(m)) m = win[i];
        return m;
    endfunction

    task automatic check_all();
        chk("in_ready",  in_ready,  m_rdy);
        chk("res_valid", res_valid, m_rep);
        chk("new_max",   new_max,   e_nmax);
        chk("new_min",   new_min,   e_nmin);
        chk("res_cnt",   res_cnt,   win.size());
        chk("res_max",   res_max,   wmax());
        chk("res_min",   res_min,   wmin());
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rdy"}, in_ready,  0);
        chk({tag, "_vld"}, res_valid, 0);
        chk({tag, "_max"}, res_max,   0);
        chk({tag, "_min"}, res_min,   0);
        chk({tag, "_cnt"}, res_cnt,   0);
        chk({tag, "_nmx"}, new_max,   0);
        chk({tag, "_nmn"}, new_min,   0);
    endtask

    // One clock: drive, advance the model across the edge, then compare.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit f, input bit rr);
        bit was;
        in_valid  = v;
        in_data   = d;
        flush     = f;
        res_ready = rr;
        @(posedge clk);
        e_nmax = 1'b0;
        e_nmin = 1'b0;
        if (m_rep) begin
            if (rr) begin
                m_rep = 1'b0;
                win.delete();
            end
        end else if (v && m_rdy) begin
            was = (win.size() > 0);
            if (was) begin
                e_nmax = sv(d) > sv(wmax());
                e_nmin = sv(d) < sv(wmin());
            end
            win.push_back(d);
            if (win.size() == WINDOW || (was && f)) m_rep = 1'b1;
        end else if (win.size() > 0 && f) begin
            m_rep = 1'b1;
        end
        m_rdy = !m_rep;
        #1;
        check_all();
    endtask

    // Async reset held across one edge; outputs must read 0 throughout.
    task automatic do_reset();
        rst_n = 1'b0;
        win.delete();
        m_rep  = 1'b0;
        m_rdy  = 1'b0;
        e_nmax = 1'b0;
        e_nmin = 1'b0;
        #1;
        check_zero("rst_a");
        @(posedge clk);
        #1;
        check_zero("rst_b");
        in_valid  = 1'b0;
        flush     = 1'b0;
        res_ready = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();
        step(0, 0, 0, 0);

        // Full window 5,2,9,9
        step(1, 4'd5, 0, 0);
        chk("tp1_nmax0", new_max, 0);
        chk("tp1_nmin0", new_min, 0);
        step(1, 4'd2, 0, 0);
        chk("tp1_nmin2", new_min, 1);
        step(1, 4'd9, 0, 0);
        chk("tp1_nmax9", new_max, 1);
        step(1, 4'd9, 0, 0);
        chk("tp1_nmax9b", new_max, 0);
        chk("tp1_vld", res_valid, 1);
        chk("tp1_max", res_max, 9);
        chk("tp1_min", res_min, 2);
        chk("tp1_cnt", res_cnt, 4);
        step(0, 0, 0, 1);

        // Flush together with the closing sample
        step(1, 4'd3, 0, 0);
        step(1, 4'd7, 1, 0);
        chk("tp2_vld", res_valid, 1);
        chk("tp2_max", res_max, 7);
        chk("tp2_min", res_min, 3);
        chk("tp2_cnt", res_cnt, 2);
        step(0, 0, 0, 1);

        // Flush while empty is ignored
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("tp3_vld", res_valid, 0);
        chk("tp3_rdy", in_ready, 1);

        // Backpressure on the result
        step(1, 4'd1, 0, 0);
        step(1, 4'd2, 0, 0);
        step(1, 4'd3, 0, 0);
        step(1, 4'd4, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'd8, 0, 0);
            chk("tp4_rdy", in_ready, 0);
            chk("tp4_max", res_max, 4);
            chk("tp4_cnt", res_cnt, 4);
        end
        step(1, 4'd8, 0, 1);
        step(1, 4'd8, 0, 0);
        chk("tp4_cnt1", res_cnt, 1);
        chk("tp4_max8", res_max, 8);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);

        // Signedness of the comparison
        step(1, 4'hF, 0, 0);
        step(1, 4'h1, 0, 0);
        step(0, 0, 1, 0);
`ifdef MINMAX_SIGNED_EN
        chk("tp5_max", res_max, 4'h1);
        chk("tp5_min", res_min, 4'hF);
`else
        chk("tp5_max", res_max, 4'hF);
        chk("tp5_min", res_min, 4'h1);
`endif
        step(0, 0, 0, 1);

        // Reset mid-window discards it
        step(1, 4'd3, 0, 0);
        step(1, 4'd4, 0, 0);
        do_reset();
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 4'd6, 0, 0);
            chk("tp6_nmax", new_max, 0);
            chk("tp6_nmin", new_min, 0);
        end
        chk("tp6_vld", res_valid, 1);
        chk("tp6_max", res_max, 6);
        chk("tp6_min", res_min, 6);
        chk("tp6_cnt", res_cnt, 4);
        step(0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, WIDTH'($urandom), ($urandom % 8) == 0,
                 ($urandom % 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/minmax_tracker.md
# minmax_tracker

Windowed running maximum/minimum tracker placed directly downstream of the magnitude-comparator stage. It accepts a stream of WIDTH-bit samples over a valid/ready handshake, and compares each sample against the stored extremes using greater/less/equal decisions. At the end of a fixed-length window, or on an explicit flush, it presents the window's max, min and sample count as a held result with its own valid/ready handshake.

## Interface
- WIDTH, 4: sample width in bits.
- WINDOW, 10: samples per window; legal range 1..2^16-1.
- CNT_W, $clog2(WINDOW+1): width of the sample counter and of res_cnt.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; one clock domain only.
- in_valid  input  1  sample present on in_data.
- in_data  input  WIDTH  sample value.
- in_ready  output  1  tracker can accept a sample; a sample is accepted when in_valid && in_ready at a rising edge.
- flush  input  1  close the current window early.
- res_valid  output  1  result fields are valid and held.
- res_ready  input  1  consumer takes the result.
- res_max  output  WIDTH  largest sample in the window.
- res_min  output  WIDTH  smallest sample in the window.
- res_cnt  output  CNT_W  number of samples in the window.
- new_max  output  1  one-cycle pulse: the last accepted sample strictly exceeded the stored max.
- new_min  output  1  one-cycle pulse: the last accepted sample was strictly below the stored min.

## Operation
- FSM states: EMPTY, TRACK, REPORT. All outputs and state reset to 0, with the FSM in EMPTY.
- **EMPTY**
  - in_ready=1.
  - An accepted sample loads max=min=in_data and sets cnt=1. new_max and new_min are not pulsed.
  - Next state is TRACK, or REPORT if WINDOW==1.
  - flush in EMPTY is ignored.
- **TRACK**
  - in_ready=1.
  - For each accepted sample, compare it against the stored max and min.
    - If sample>max: max=sample and pulse new_max.
    - If sample<min: min=sample and pulse new_min.
    - Equal values change nothing and pulse nothing.
  - cnt increments on each accepted sample.
  - Go to REPORT when the accepted sample makes cnt==WINDOW, or when flush=1.
  - flush together with an accepted sample: the sample is included first, then the window closes.
- **REPORT**
  - in_ready=0 and res_valid=1.
  - res_max, res_min and res_cnt stay stable until res_ready=1.
  - On res_valid&&res_ready, go to EMPTY and clear max, min and cnt to 0.
  - flush and in_valid are ignored in REPORT.
- res_max, res_min and res_cnt always mirror the internal registers, so they are live in TRACK. They are qualified only by res_valid.
- Reset asserted mid-window discards the window. After rst_n deasserts, the first accepted sample starts a fresh window.

## Timing
- Single-cycle acceptance with no bubbles in EMPTY or TRACK.
- A sample accepted at edge N is reflected in max, min, cnt and the new_max/new_min pulses after edge N. Each pulse lasts exactly one cycle.
- The window-closing sample or flush at edge N produces res_valid=1 from edge N onward. in_ready drops in the same cycle.
- Result handshake at edge M: res_valid=0 and in_ready=1 after edge M. Minimum back-to-back window turnaround is one idle acceptance cycle.
- in_ready does not depend combinationally on in_valid. res_valid does not depend combinationally on res_ready.

## Configuration
- MINMAX_SIGNED_EN
  - Defined: samples and stored extremes are compared as two's-complement signed values.
  - Undefined: comparisons are unsigned.
  - Storage, widths and handshakes are identical in both builds.

## Structure
- Shared package minmax_pkg holds the state enum type (EMPTY, TRACK, REPORT) and the function computing CNT_W.
- One sub-module, mag_cmp: parameterised WIDTH, purely combinational, producing gt/lt/eq. It honours MINMAX_SIGNED_EN.
- The tracker instantiates mag_cmp twice: sample vs max, and sample vs min.

## Test plan
- WIDTH=4, WINDOW=4, samples 5,2,9,9 back-to-back
  - Required: res_valid one cycle after the 4th acceptance, res_max=9, res_min=2, res_cnt=4.
  - Required: new_max pulses only on 9 (the first one); new_min pulses only on 2.
- Flush with a sample: samples 3,7, with flush=1 asserted alongside the 7
  - Required: res_max=7, res_min=3, res_cnt=2.
- Flush in EMPTY
  - Required: res_valid stays 0 and in_ready stays 1.
- Backpressure: hold res_ready=0 for 5 cycles while driving in_valid=1
  - Required: in_ready=0 throughout, result fields unchanged, no sample lost.
  - Required: after res_ready=1, the next sample starts a new window with cnt=1.
- Signed build: samples 4'hF,4'h1 then flush
  - Unsigned build: res_max=F, res_min=1.
  - MINMAX_SIGNED_EN build: res_max=1, res_min=F.
- Reset mid-window: 2 samples accepted, rst_n=0 for 1 cycle, then samples 6,6,6,6
  - Required: all outputs 0 during reset.
  - Required: result res_max=6, res_min=6, res_cnt=4, with no new_max/new_min pulses.
